// File: rtl/scaler_h_ctrl.sv
// Frame-synchronous front-end for scaler_h: range-checked step register applied only in
// vertical blanking, whole-frame stream gating, and input geometry measurement.
module scaler_h_ctrl #(
    parameter logic [15:0] STEP       = 16'd4096,
    parameter logic [15:0] STEP_MIN   = 16'd1024,
    parameter logic [15:0] STEP_MAX   = 16'd16383,
    parameter int          DATA_WIDTH = 8,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           cfg_step_i,
    input  logic                  cfg_wr_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_clr_i,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  de_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [15:0]           scale_step_o,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  busy_o,
    output logic                  pend_o,
    output logic [CNT_WIDTH-1:0]  line_len_o,
    output logic [CNT_WIDTH-1:0]  frame_h_o,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o,
    output logic                  err_step_o,
    output logic                  err_line_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, RUN = 2'd2} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_t                  state_q, state_d;
    logic [15:0]             step_q, step_d, pend_val_q, pend_val_d;
    logic                    pend_q, pend_d, err_step_q, err_step_d, err_line_q, err_line_d;
    logic [DATA_WIDTH-1:0]   do_q, do_d;
    logic                    de_q, de_d, hs_q, hs_d, vs_q, vs_d, busy_q, busy_d;
    logic                    hs_prev_q, vs_prev_q, ref_vld_q, ref_vld_d;
    logic [CNT_WIDTH-1:0]    pix_q, pix_d, line_cnt_q, line_cnt_d, line_len_q, line_len_d;
    logic [CNT_WIDTH-1:0]    frame_h_q, frame_h_d, frame_cnt_q, frame_cnt_d, ref_len_q, ref_len_d;
    logic                    step_ok_s, apply_s, hs_rise_s, vs_rise_s, line_end_s, line_err_s;
    logic [CNT_WIDTH-1:0]    line_cnt_tmp_s;

    // Frame-gating state machine: enable changes only take effect in blanking
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_en_i) state_d = WAIT_VS; else state_d = IDLE;
            WAIT_VS: if (!cfg_en_i) state_d = IDLE;
                     else if (vs_i) state_d = RUN;
                     else state_d = WAIT_VS;
            RUN:     if (vs_i && !cfg_en_i) state_d = IDLE; else state_d = RUN;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    // Step configuration: the pending value moves to the scaler only during blanking
    always_comb begin
        step_ok_s  = (cfg_step_i >= STEP_MIN) && (cfg_step_i <= STEP_MAX);
        apply_s    = vs_i && pend_q;
        step_d     = step_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (apply_s) begin
            step_d = pend_val_q;
            pend_d = 1'b0;
        end else begin
            step_d = step_q;
        end
        if (cfg_wr_i && step_ok_s) begin
            pend_val_d = cfg_step_i;
            pend_d     = 1'b1;
        end else begin
            pend_val_d = pend_val_q;
        end
        if (cfg_wr_i && !step_ok_s) err_step_d = 1'b1;
        else if (cfg_clr_i)         err_step_d = 1'b0;
        else                        err_step_d = err_step_q;
    end

    // Video gating: a one-cycle copy while running, idle levels otherwise
    always_comb begin
        do_d = do_q;
        de_d = 1'b0;
        hs_d = 1'b1;
        vs_d = 1'b1;
        if (state_q == RUN) begin
            do_d = di_i;
            de_d = de_i;
            hs_d = hs_i;
            vs_d = vs_i;
        end else begin
            do_d = do_q;
        end
    end

    // Geometry measurement and line-length consistency check
    always_comb begin
        hs_rise_s  = hs_i && !hs_prev_q;
        vs_rise_s  = vs_i && !vs_prev_q;
        line_end_s = hs_rise_s && (pix_q != CNT_ZERO);
        line_err_s = 1'b0;
        ref_len_d  = ref_len_q;
        ref_vld_d  = ref_vld_q;
        if (line_end_s)  pix_d = de_i ? CNT_ONE : CNT_ZERO;
        else if (de_i)   pix_d = sat_inc(pix_q);
        else             pix_d = pix_q;
        line_len_d     = line_end_s ? pix_q : line_len_q;
        line_cnt_tmp_s = line_end_s ? sat_inc(line_cnt_q) : line_cnt_q;
        if (line_end_s && !ref_vld_q) begin
            ref_len_d = pix_q;
            ref_vld_d = 1'b1;
        end else if (line_end_s && (pix_q != ref_len_q)) begin
            line_err_s = 1'b1;
        end else begin
            line_err_s = 1'b0;
        end
        // A line closing on the vs edge is already folded into line_cnt_tmp_s
        if (vs_rise_s) begin
            frame_h_d   = line_cnt_tmp_s;
            line_cnt_d  = CNT_ZERO;
            frame_cnt_d = (state_q == RUN) ? frame_cnt_q + CNT_ONE : frame_cnt_q;
            ref_vld_d   = 1'b0;
        end else begin
            frame_h_d   = frame_h_q;
            line_cnt_d  = line_cnt_tmp_s;
            frame_cnt_d = frame_cnt_q;
        end
        if (line_err_s)     err_line_d = 1'b1;
        else if (cfg_clr_i) err_line_d = 1'b0;
        else                err_line_d = err_line_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            step_q      <= STEP;
            pend_val_q  <= STEP;
            pend_q      <= 1'b0;
            err_step_q  <= 1'b0;
            err_line_q  <= 1'b0;
            do_q        <= {DATA_WIDTH{1'b0}};
            de_q        <= 1'b0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            busy_q      <= 1'b0;
            hs_prev_q   <= 1'b1;
            vs_prev_q   <= 1'b1;
            ref_vld_q   <= 1'b0;
            ref_len_q   <= CNT_ZERO;
            pix_q       <= CNT_ZERO;
            line_cnt_q  <= CNT_ZERO;
            line_len_q  <= CNT_ZERO;
            frame_h_q   <= CNT_ZERO;
            frame_cnt_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            pend_val_q  <= pend_val_d;
            pend_q      <= pend_d;
            err_step_q  <= err_step_d;
            err_line_q  <= err_line_d;
            do_q        <= do_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            busy_q      <= busy_d;
            hs_prev_q   <= hs_i;
            vs_prev_q   <= vs_i;
            ref_vld_q   <= ref_vld_d;
            ref_len_q   <= ref_len_d;
            pix_q       <= pix_d;
            line_cnt_q  <= line_cnt_d;
            line_len_q  <= line_len_d;
            frame_h_q   <= frame_h_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign scale_step_o = step_q;
    assign do_o         = do_q;
    assign de_o         = de_q;
    assign hs_o         = hs_q;
    assign vs_o         = vs_q;
    assign busy_o       = busy_q;
    assign pend_o       = pend_q;
    assign line_len_o   = line_len_q;
    assign frame_h_o    = frame_h_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign err_step_o   = err_step_q;
    assign err_line_o   = err_line_q;

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Randomized self-checking bench for scaler_h_ctrl against a frame/line-level reference model.
module tb_scaler_h_ctrl;

    localparam int BLANK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_step_i;
    logic        cfg_wr_i, cfg_en_i, cfg_clr_i;
    logic [7:0]  di_i;
    logic        de_i, hs_i, vs_i;
    logic [15:0] scale_step_o, line_len_o, frame_h_o, frame_cnt_o;
    logic [7:0]  do_o;
    logic        de_o, hs_o, vs_o, busy_o, pend_o, err_step_o, err_line_o;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic        m_run, m_en_prev, m_vs_prev, m_pend, m_err_step, m_err_line;
    logic [15:0] m_step, m_pend_val, m_frame_cnt;
    logic [7:0]  m_do;

    scaler_h_ctrl dut (
        .clk(clk), .rst(rst), .cfg_step_i(cfg_step_i), .cfg_wr_i(cfg_wr_i),
        .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i), .di_i(di_i), .de_i(de_i),
        .hs_i(hs_i), .vs_i(vs_i), .scale_step_o(scale_step_o), .do_o(do_o),
        .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .busy_o(busy_o), .pend_o(pend_o),
        .line_len_o(line_len_o), .frame_h_o(frame_h_o), .frame_cnt_o(frame_cnt_o),
        .err_step_o(err_step_o), .err_line_o(err_line_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_en_prev = 1'b0; m_vs_prev = 1'b1; m_pend = 1'b0;
        m_err_step = 1'b0; m_err_line = 1'b0; m_step = 16'd4096; m_pend_val = 16'd4096;
        m_frame_cnt = 16'd0; m_do = 8'd0;
    endtask

    // One clock: advance the model with the inputs seen at this edge, then compare.
    task automatic tick();
        logic run_old, e_de, e_hs, e_vs, ok;
        @(posedge clk);
        #1;
        run_old = m_run;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
        if (run_old) begin
            e_de = de_i; e_hs = hs_i; e_vs = vs_i; m_do = di_i;
        end
        // an enable seen for at least one cycle before a blanking cycle starts passing frames
        if (vs_i) m_run = cfg_en_i && m_en_prev;
        m_en_prev = cfg_en_i;
        if (vs_i && !m_vs_prev && run_old) m_frame_cnt = m_frame_cnt + 16'd1;
        m_vs_prev = vs_i;
        ok = (cfg_step_i >= 16'd1024) && (cfg_step_i <= 16'd16383);
        if (vs_i && m_pend) begin
            m_step = m_pend_val;
            m_pend = 1'b0;
        end
        if (cfg_wr_i && ok) begin
            m_pend_val = cfg_step_i;
            m_pend = 1'b1;
        end
        if (cfg_wr_i && !ok) m_err_step = 1'b1;
        else if (cfg_clr_i) m_err_step = 1'b0;
        if (cfg_clr_i) m_err_line = 1'b0;
        check_eq("de_o", de_o, e_de);
        check_eq("hs_o", hs_o, e_hs);
        check_eq("vs_o", vs_o, e_vs);
        check_eq("do_o", do_o, m_do);
        check_eq("busy_o", busy_o, m_run);
        check_eq("scale_step_o", scale_step_o, m_step);
        check_eq("pend_o", pend_o, m_pend);
        check_eq("err_step_o", err_step_o, m_err_step);
        check_eq("frame_cnt_o", frame_cnt_o, m_frame_cnt);
    endtask

    task automatic cfg_write(input logic [15:0] v, input logic clr);
        cfg_step_i = v; cfg_wr_i = 1'b1; cfg_clr_i = clr;
        tick();
        cfg_wr_i = 1'b0; cfg_clr_i = 1'b0;
    endtask

    task automatic clear_errors();
        cfg_clr_i = 1'b1;
        tick();
        cfg_clr_i = 1'b0;
        check_eq("err_line_clr", err_line_o, m_err_line);
    endtask

    // One frame: active lines then blanking. Optional mid-frame write / enable change,
    // one short or long line, a write in the first blanking cycle, and a last line that
    // closes on the same edge as vs rises.
    task automatic send_frame(input int nlines, input int len, input int bad_line, input int bad_len,
                              input int wr_line, input int wr_val, input int en_line,
                              input logic en_val, input logic coincide, input int blank_wr);
        int  first, cur;
        logic last;
        vs_i = 1'b0; hs_i = 1'b1; de_i = 1'b0;
        tick();
        first = 0;
        for (int l = 0; l < nlines; l++) begin
            last = (l == nlines - 1);
            if (l == en_line) cfg_en_i = en_val;
            if (l == wr_line) cfg_write(wr_val[15:0], 1'b0);
            cur = (l == bad_line) ? bad_len : len;
            hs_i = 1'b0;
            for (int p = 0; p < cur; p++) begin
                de_i = 1'b1; di_i = 8'($urandom);
                tick();
                de_i = 1'b0; di_i = 8'($urandom);
                tick();
            end
            hs_i = 1'b1;
            if (last && coincide) vs_i = 1'b1;
            tick();
            if (l == 0) first = cur;
            else if (cur != first) m_err_line = 1'b1;
            check_eq("line_len_o", line_len_o, cur);
            check_eq("err_line_o", err_line_o, m_err_line);
            if (!(last && coincide)) tick();
        end
        if (!coincide) begin
            vs_i = 1'b1;
            if (blank_wr >= 0) begin
                cfg_step_i = blank_wr[15:0]; cfg_wr_i = 1'b1;
            end
            tick();
            cfg_wr_i = 1'b0;
        end
        check_eq("frame_h_o", frame_h_o, nlines);
        for (int b = 1; b < BLANK; b++) tick();
    endtask

    initial begin
        int nl, ln, bl, wl, bw;
        model_reset();
        rst = 1'b0; cfg_step_i = 16'd0; cfg_wr_i = 1'b0; cfg_en_i = 1'b0; cfg_clr_i = 1'b0;
        di_i = 8'd0; de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1;
        #12;
        check_eq("rst_step", scale_step_o, 16'd4096);
        check_eq("rst_de", de_o, 1'b0);
        check_eq("rst_hs", hs_o, 1'b1);
        check_eq("rst_vs", vs_o, 1'b1);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_pend", pend_o, 1'b0);
        check_eq("rst_fcnt", frame_cnt_o, 16'd0);
        rst = 1'b1;

        // 1: pass-through of 25x25 frames with the default step
        cfg_en_i = 1'b1;
        for (int b = 0; b < BLANK; b++) tick();
        send_frame(25, 25, -1, 0, -1, 0, -1, 1'b1, 1'b0, -1);
        send_frame(25, 25, -1, 0, -1, 0, -1, 1'b1, 1'b0, -1);
        check_eq("frame_cnt_2", frame_cnt_o, 16'd2);
        check_eq("line_len_25", line_len_o, 16'd25);

        // 2: mid-frame write applied at the next blanking; then write-and-apply overlap
        send_frame(25, 25, -1, 0, 5, 2867, -1, 1'b1, 1'b0, -1);
        check_eq("step_2867", scale_step_o, 16'd2867);
        send_frame(6, 5, -1, 0, 2, 8192, -1, 1'b1, 1'b0, 3000);
        check_eq("step_overlap", scale_step_o, 16'd3000);

        // 3: out-of-range writes and error clear, including clear colliding with an error
        cfg_write(16'd500, 1'b0);
        cfg_write(16'd20000, 1'b0);
        cfg_write(16'd1023, 1'b1);
        cfg_write(16'd16384, 1'b0);
        clear_errors();
        cfg_write(16'd1024, 1'b0);
        cfg_write(16'd16383, 1'b0);
        tick();

        // 4: disable at line 10, then re-enable mid-frame
        send_frame(25, 25, -1, 0, -1, 0, 10, 1'b0, 1'b0, -1);
        send_frame(25, 25, -1, 0, -1, 0, 5, 1'b1, 1'b0, -1);
        send_frame(8, 6, -1, 0, -1, 0, -1, 1'b1, 1'b0, -1);

        // 5: short line 7 and a last line closing on the vs edge
        send_frame(25, 25, 6, 24, -1, 0, -1, 1'b1, 1'b0, -1);
        clear_errors();
        send_frame(7, 4, -1, 0, -1, 0, -1, 1'b1, 1'b1, -1);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            nl = $urandom_range(3, 6);
            ln = $urandom_range(2, 6);
            bl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nl - 1) : -1;
            wl = ($urandom_range(0, 1) == 0) ? $urandom_range(0, nl - 1) : -1;
            bw = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 20000) : -1;
            send_frame(nl, ln, bl, ln + 1, wl, $urandom_range(0, 20000), -1, 1'b1,
                       1'($urandom_range(0, 1)), bw);
            if ($urandom_range(0, 1) == 0) clear_errors();
        end

        // 6: asynchronous reset in the middle of a line
        cfg_write(16'd600, 1'b0);
        vs_i = 1'b0; hs_i = 1'b0;
        for (int p = 0; p < 3; p++) begin
            de_i = 1'b1; di_i = 8'hA5; tick();
        end
        #2 rst = 1'b0;
        #1;
        check_eq("arst_step", scale_step_o, 16'd4096);
        check_eq("arst_de", de_o, 1'b0);
        check_eq("arst_hs", hs_o, 1'b1);
        check_eq("arst_vs", vs_o, 1'b1);
        check_eq("arst_do", do_o, 8'd0);
        check_eq("arst_busy", busy_o, 1'b0);
        check_eq("arst_pend", pend_o, 1'b0);
        check_eq("arst_len", line_len_o, 16'd0);
        check_eq("arst_fh", frame_h_o, 16'd0);
        check_eq("arst_fcnt", frame_cnt_o, 16'd0);
        check_eq("arst_errs", err_step_o, 1'b0);
        check_eq("arst_errl", err_line_o, 1'b0);
        model_reset();
        de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int b = 0; b < BLANK; b++) tick();
        send_frame(4, 4, -1, 0, -1, 0, -1, 1'b1, 1'b0, -1);
        check_eq("post_rst_fcnt", frame_cnt_o, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
